// File: rtl/nqcpu_pkg.sv
// Shared types and constants for the nqcpu memory stage.
package nqcpu_pkg;

  // Memory stage FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Bit positions inside the 4-bit mem-op flag vector {rd_b, rd_w, wr_b, wr_w}.
  localparam int unsigned OP_WR_W = 0;
  localparam int unsigned OP_WR_B = 1;
  localparam int unsigned OP_RD_W = 2;
  localparam int unsigned OP_RD_B = 3;

  // Byte-lane enables {hi, lo}; lanes are little-endian.
  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;
  localparam logic [1:0] BE_W  = 2'b11;

  // Number of op flags raised; more than one is an illegal request.
  function automatic logic [2:0] op_count(input logic [3:0] flags);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, flags[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering between the 16-bit data bus and byte/word requests.
module mem_lane_align
  import nqcpu_pkg::*;
(
  input  logic        addr0,      // byte address bit 0 of the captured request
  input  logic        word,       // 1 = word access, 0 = byte access
  input  logic [15:0] wdata,      // captured store data
  input  logic [15:0] rdata,      // raw bus read data
  output logic [1:0]  be,
  output logic [15:0] bus_wdata,
  output logic [15:0] rf_data,
  output logic        rf_hb,
  output logic        rf_lb
);

  // Byte stores replicate the low byte on both lanes so the enabled lane carries it;
  // byte loads pull the addressed lane down into the low byte, zero-extended.
  always_comb begin
    be        = BE_W;
    bus_wdata = wdata;
    rf_data   = rdata;
    rf_hb     = 1'b1;
    rf_lb     = 1'b1;
    if (!word) begin
      be        = addr0 ? BE_HI : BE_LO;
      bus_wdata = {wdata[7:0], wdata[7:0]};
      rf_data   = {8'h00, (addr0 ? rdata[15:8] : rdata[7:0])};
      rf_hb     = 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Load/store stage: one bus_req/bus_ack transaction per accepted en, with timeout abort,
// illegal-request faulting and load writeback to the register file.
//
// Bus handshake: bus_req rises in the first REQ cycle and stays high, with bus_addr,
// bus_we, bus_be and bus_wdata held stable, until bus_ack is sampled high on a rising
// edge (read data is taken from bus_rdata in that same cycle) or the timeout expires.
// bus_ack outside REQ has no effect.
module mem_stage
  import nqcpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255  // REQ cycles without ack before abort; 0 = never
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        rd_b,
  input  logic        rd_w,
  input  logic        wr_b,
  input  logic        wr_w,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [2:0]  reg_dest,
  input  logic [15:0] pc_in,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] fault_pc,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [1:0]  bus_be,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        rf_we,
  output logic [2:0]  rf_dest,
  output logic [15:0] rf_data,
  output logic        rf_hb,
  output logic        rf_lb,
  output logic [1:0]  dbg_state
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e        state_q;
  logic [15:0]   addr_q;
  logic [15:0]   wdata_q;
  logic [2:0]    dest_q;
  logic [15:0]   pc_q;
  logic          word_q;
  logic          we_q;
  logic          load_q;
  logic [CW-1:0] cnt_q;
  logic          bus_req_q;
  logic          done_q;
  logic          fault_q;
  logic [15:0]   fault_pc_q;
  logic          rf_we_q;
  logic [2:0]    rf_dest_q;
  logic [15:0]   rf_data_q;
  logic          rf_hb_q;
  logic          rf_lb_q;

  logic [3:0]    flags;
  logic [2:0]    n_ops;
  logic          word_in;
  logic          illegal;
  logic          timeout_hit;

  logic [1:0]    al_be;
  logic [15:0]   al_wdata;
  logic [15:0]   al_rf_data;
  logic          al_rf_hb;
  logic          al_rf_lb;

  assign flags   = {rd_b, rd_w, wr_b, wr_w};
  assign n_ops   = op_count(flags);
  assign word_in = flags[OP_RD_W] | flags[OP_WR_W];
  assign illegal = (n_ops > 3'd1) || ((n_ops == 3'd1) && word_in && addr[0]);

  // True in the REQ cycle that completes TIMEOUT consecutive cycles without ack.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

  mem_lane_align u_align (
    .addr0     (addr_q[0]),
    .word      (word_q),
    .wdata     (wdata_q),
    .rdata     (bus_rdata),
    .be        (al_be),
    .bus_wdata (al_wdata),
    .rf_data   (al_rf_data),
    .rf_hb     (al_rf_hb),
    .rf_lb     (al_rf_lb)
  );

  // FSM, captured request, timeout counter and registered completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      dest_q     <= '0;
      pc_q       <= '0;
      word_q     <= 1'b0;
      we_q       <= 1'b0;
      load_q     <= 1'b0;
      cnt_q      <= '0;
      bus_req_q  <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      rf_we_q    <= 1'b0;
      rf_dest_q  <= '0;
      rf_data_q  <= '0;
      rf_hb_q    <= 1'b0;
      rf_lb_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rf_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            pc_q   <= pc_in;
            dest_q <= reg_dest;
            if (illegal) begin
              state_q    <= ST_FIN;
              done_q     <= 1'b1;
              fault_q    <= 1'b1;
              fault_pc_q <= pc_in;
            end else if (n_ops == 3'd0) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_REQ;
              bus_req_q <= 1'b1;
              addr_q    <= addr;
              wdata_q   <= wdata;
              word_q    <= word_in;
              we_q      <= flags[OP_WR_B] | flags[OP_WR_W];
              load_q    <= flags[OP_RD_B] | flags[OP_RD_W];
              cnt_q     <= '0;
            end
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            // Ack beats a timeout landing in the same cycle.
            bus_req_q <= 1'b0;
            state_q   <= ST_FIN;
            done_q    <= 1'b1;
            if (load_q) begin
              rf_we_q   <= 1'b1;
              rf_dest_q <= dest_q;
              rf_data_q <= al_rf_data;
              rf_hb_q   <= al_rf_hb;
              rf_lb_q   <= al_rf_lb;
            end
          end else if (timeout_hit) begin
            bus_req_q  <= 1'b0;
            state_q    <= ST_FIN;
            done_q     <= 1'b1;
            fault_q    <= 1'b1;
            fault_pc_q <= pc_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_FIN: begin
          state_q   <= ST_IDLE;
          rf_dest_q <= '0;
          rf_data_q <= '0;
          rf_hb_q   <= 1'b0;
          rf_lb_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus fields are only driven while a request is outstanding.
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_req_q & we_q;
  assign bus_addr  = bus_req_q ? {addr_q[15:1], 1'b0} : 16'h0000;
  assign bus_be    = bus_req_q ? al_be : 2'b00;
  assign bus_wdata = bus_req_q ? al_wdata : 16'h0000;

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;
  assign rf_we     = rf_we_q;
  assign rf_dest   = rf_dest_q;
  assign rf_data   = rf_data_q;
  assign rf_hb     = rf_hb_q;
  assign rf_lb     = rf_lb_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: driver tasks push expectations, a negedge monitor checks them.
module tb_mem_stage;

  typedef struct packed {
    logic [15:0] cyc;     // latency from en cycle on issue, absolute done cycle once queued
    logic        fault;
    logic        rf_we;
    logic [15:0] rf_data;
    logic        hb;
    logic        lb;
    logic [2:0]  dest;
    logic [15:0] fpc;
    logic [7:0]  reqs;    // number of cycles bus_req was high
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        chk_wdata;
  } bus_t;

  localparam logic [3:0] RDB = 4'b1000;
  localparam logic [3:0] RDW = 4'b0100;
  localparam logic [3:0] WRB = 4'b0010;
  localparam logic [3:0] WRW = 4'b0001;
  localparam bus_t NOBUS = '0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, rd_b = 1'b0, rd_w = 1'b0, wr_b = 1'b0, wr_w = 1'b0;
  logic [15:0] addr = '0, wdata = '0, pc_in = '0;
  logic [2:0]  reg_dest = '0;
  logic        busy, done, fault, bus_req, bus_we;
  logic [15:0] fault_pc, bus_addr, bus_wdata;
  logic [1:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = '0;
  logic        rf_we, rf_hb, rf_lb;
  logic [2:0]  rf_dest;
  logic [15:0] rf_data;
  logic [1:0]  dbg_state;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rd_b(rd_b), .rd_w(rd_w), .wr_b(wr_b), .wr_w(wr_w),
    .addr(addr), .wdata(wdata), .reg_dest(reg_dest), .pc_in(pc_in),
    .busy(busy), .done(done), .fault(fault), .fault_pc(fault_pc),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data), .rf_hb(rf_hb), .rf_lb(rf_lb),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus responder: acks after rsp_wait wait states unless rsp_noack; stray_ack pokes ack while idle.
  int          rsp_wait = 0;
  bit          rsp_noack = 1'b0;
  logic [15:0] rsp_data = '0;
  int          rsp_seen = 0;
  bit          stray_ack = 1'b0;

  always @(negedge clk) begin
    if (bus_req) begin
      if (!rsp_noack && rsp_seen >= rsp_wait) begin
        bus_ack   = 1'b1;
        bus_rdata = rsp_data;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = 16'h5555;
      end
      rsp_seen++;
    end else begin
      rsp_seen  = 0;
      bus_ack   = stray_ack;
      bus_rdata = stray_ack ? 16'hFFFF : 16'h0000;
    end
  end

  // Monitor: checks bus fields every REQ cycle and the completion record on every done.
  bus_t cur_bus;
  bit   have_bus = 1'b0;
  int   req_run = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      req_run  = 0;
      have_bus = 1'b0;
    end else begin
      if (bus_req) begin
        if (req_run == 0) begin
          if (bus_q.size() == 0) check("unexpected_bus_req", 32'(bus_req), 32'd0);
          else begin
            cur_bus  = bus_q.pop_front();
            have_bus = 1'b1;
          end
        end
        if (have_bus) begin
          check("bus_we", 32'(bus_we), 32'(cur_bus.we));
          check("bus_addr", 32'(bus_addr), 32'(cur_bus.addr));
          check("bus_be", 32'(bus_be), 32'(cur_bus.be));
          if (cur_bus.chk_wdata) check("bus_wdata", 32'(bus_wdata), 32'(cur_bus.wdata));
        end
        req_run++;
      end
      if ((fault || rf_we) && !done) check("pulse_without_done", 32'(done), 32'd1);
      if (done) begin
        if (exp_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          check("fault", 32'(fault), 32'(e.fault));
          check("rf_we", 32'(rf_we), 32'(e.rf_we));
          check("fault_pc", 32'(fault_pc), 32'(e.fpc));
          check("req_cycles", 32'(req_run), 32'(e.reqs));
          if (e.rf_we) begin
            check("rf_data", 32'(rf_data), 32'(e.rf_data));
            check("rf_hb", 32'(rf_hb), 32'(e.hb));
            check("rf_lb", 32'(rf_lb), 32'(e.lb));
            check("rf_dest", 32'(rf_dest), 32'(e.dest));
          end
        end
        req_run  = 0;
        have_bus = 1'b0;
      end
    end
  end

  // Driver: called #1 after a rising edge; en is high for exactly that cycle (cycle T).
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] wd,
                       input logic [2:0] dest, input logic [15:0] pc, input int wt,
                       input bit noack, input logic [15:0] rdat, input bit has_bus,
                       input bus_t b, input exp_t e, input bit wait_done, input bit poke);
    int k;
    rsp_wait  = wt;
    rsp_noack = noack;
    rsp_data  = rdat;
    {rd_b, rd_w, wr_b, wr_w} = op;
    addr = a; wdata = wd; reg_dest = dest; pc_in = pc; en = 1'b1;
    if (has_bus) bus_q.push_back(b);
    if (wait_done) begin
      e.cyc = e.cyc + 16'(cyc);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    en = 1'b0; {rd_b, rd_w, wr_b, wr_w} = 4'b0000;
    if (poke) begin
      // A misaligned word store while busy must be ignored.
      {rd_b, rd_w, wr_b, wr_w} = WRW; addr = 16'h0FF1; en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0; {rd_b, rd_w, wr_b, wr_w} = 4'b0000;
    end
    if (wait_done) begin
      k = 0;
      while (!done && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      if (!done) check("done_timeout", 32'(done), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_pc", 32'(fault_pc), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1 word load, zero wait, then back-to-back byte load odd with 2 waits and a busy poke
    issue(RDW, 16'h0100, 16'h0000, 3'd3, 16'h0010, 0, 0, 16'hBEEF, 1,
          '{1'b0, 16'h0100, 2'b11, 16'h0000, 1'b0},
          '{16'd2, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1, 3'd3, 16'h0000, 8'd1}, 1, 0);
    issue(RDB, 16'h0201, 16'h0000, 3'd5, 16'h0014, 2, 0, 16'h12AB, 1,
          '{1'b0, 16'h0200, 2'b10, 16'h0000, 1'b0},
          '{16'd4, 1'b0, 1'b1, 16'h0012, 1'b0, 1'b1, 3'd5, 16'h0000, 8'd3}, 1, 1);
    // 3 stores: byte even, byte odd, word with one wait
    issue(WRB, 16'h0300, 16'h5A77, 3'd0, 16'h0018, 0, 0, 16'h0000, 1,
          '{1'b1, 16'h0300, 2'b01, 16'h7777, 1'b1},
          '{16'd2, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 8'd1}, 1, 0);
    issue(WRB, 16'h0305, 16'h00C3, 3'd0, 16'h001C, 0, 0, 16'h0000, 1,
          '{1'b1, 16'h0304, 2'b10, 16'hC3C3, 1'b1},
          '{16'd2, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 8'd1}, 1, 0);
    issue(WRW, 16'h0302, 16'h1234, 3'd0, 16'h0020, 1, 0, 16'h0000, 1,
          '{1'b1, 16'h0302, 2'b11, 16'h1234, 1'b1},
          '{16'd3, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 8'd2}, 1, 0);
    // Stray ack while idle, then byte load even lane
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    issue(RDB, 16'h0210, 16'h0000, 3'd1, 16'h0024, 0, 0, 16'h12AB, 1,
          '{1'b0, 16'h0210, 2'b01, 16'h0000, 1'b0},
          '{16'd2, 1'b0, 1'b1, 16'h00AB, 1'b0, 1'b1, 3'd1, 16'h0000, 8'd1}, 1, 0);
    // 4 illegal requests and a no-op
    issue(WRW, 16'h0401, 16'hAAAA, 3'd0, 16'h0040, 0, 0, 16'h0000, 0, NOBUS,
          '{16'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0040, 8'd0}, 1, 0);
    issue(RDB | WRB, 16'h0402, 16'h0000, 3'd0, 16'h0044, 0, 0, 16'h0000, 0, NOBUS,
          '{16'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0044, 8'd0}, 1, 0);
    issue(4'b0000, 16'h0403, 16'h0000, 3'd0, 16'h0048, 0, 0, 16'h0000, 0, NOBUS,
          '{16'd1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0044, 8'd0}, 1, 0);
    // 5 timeout with no ack, then ack on the cycle the count reaches TIMEOUT
    issue(RDW, 16'h0500, 16'h0000, 3'd4, 16'h0050, 0, 1, 16'h0000, 1,
          '{1'b0, 16'h0500, 2'b11, 16'h0000, 1'b0},
          '{16'd5, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0050, 8'd4}, 1, 0);
    issue(RDW, 16'h0600, 16'h0000, 3'd7, 16'h0054, 3, 0, 16'hCAFE, 1,
          '{1'b0, 16'h0600, 2'b11, 16'h0000, 1'b0},
          '{16'd5, 1'b0, 1'b1, 16'hCAFE, 1'b1, 1'b1, 3'd7, 16'h0050, 8'd4}, 1, 0);
    // 6 async reset during REQ
    issue(RDW, 16'h0680, 16'h0000, 3'd6, 16'h0060, 0, 1, 16'h0000, 1,
          '{1'b0, 16'h0680, 2'b11, 16'h0000, 1'b0}, '0, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_bus_req", 32'(bus_req), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_noack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_rf_we", 32'(rf_we), 32'd0);
      check("post_rst_bus_req", 32'(bus_req), 32'd0);
    end
    check("post_rst_fault_pc", 32'(fault_pc), 32'd0);
    issue(RDW, 16'h0700, 16'h0000, 3'd2, 16'h0070, 0, 0, 16'h0F0F, 1,
          '{1'b0, 16'h0700, 2'b11, 16'h0000, 1'b0},
          '{16'd2, 1'b0, 1'b1, 16'h0F0F, 1'b1, 1'b1, 3'd2, 16'h0000, 8'd1}, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
